// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between requesters, the round-robin
// arbiter and the downstream 8-to-3 encoder.
//   req     [7:0]  request lines, bit i = requester i
//   ack            consumer finished with the current grant (one-cycle pulse)
//   grant   [7:0]  registered one-hot grant, bit i drives encoder input a<i>
//   gnt_en         high while grant is non-zero, drives encoder en
//   busy           high while a grant is outstanding
//   timeout        one-cycle pulse on forced release
// Modports: slave = arbiter side, master = requester/consumer side.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       ack;
    logic [7:0] grant;
    logic       gnt_en;
    logic       busy;
    logic       timeout;

    modport slave (
        input  req,
        input  ack,
        output grant,
        output gnt_en,
        output busy,
        output timeout
    );

    modport master (
        output req,
        output ack,
        input  grant,
        input  gnt_en,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter feeding an 8-to-3 encoder.
// A request seen in IDLE is granted on the next edge; the grant is held until
// ack, after which priority rotates to the index just past the served one.
// There is always at least one IDLE cycle (grant=0, gnt_en=0) between grants.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      rr_arbiter8_if.slave (req, ack in; grant, gnt_en, busy, timeout out)
// Parameters:
//   TIMEOUT  cycles a grant may be held without ack (2..255), only used when
//            RR_ARB_TIMEOUT_EN is defined.
// Build option:
//   RR_ARB_TIMEOUT_EN  when defined, an unacknowledged grant is force-released
//                      after TIMEOUT cycles and timeout pulses; otherwise the
//                      grant is held until ack or rst and timeout is tied 0.
module rr_arbiter8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    rr_arbiter8_if.slave bus
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_check
        $error("rr_arbiter8: TIMEOUT must be in 2..255");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] gidx_q, gidx_d;   // index of the outstanding grant
    logic [2:0] ptr_q, ptr_d;     // highest-priority index for the next scan
    logic       gnt_en_q, gnt_en_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       expire;

    // Rotating scan: first set request starting at ptr_q, wrapping mod 8.
    logic [2:0] sel;
    logic [2:0] scan_idx;
    logic       found;

    always_comb begin
        found    = 1'b0;
        sel      = ptr_q;
        scan_idx = '0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Held at zero while idle, so it is zero on entry to GRANT.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (!bus.ack) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack in the expiry cycle is a normal release, not a timeout.
    assign expire = (state_q == StGrant) && (cnt_q == 8'(TIMEOUT - 1)) && !bus.ack;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        gnt_en_d  = gnt_en_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                grant_d  = '0;
                gnt_en_d = 1'b0;
                busy_d   = 1'b0;
                if (found) begin
                    state_d  = StGrant;
                    grant_d  = 8'd1 << sel;
                    gidx_d   = sel;
                    gnt_en_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StGrant: begin
                // Requests are not sampled here; only ack or expiry release.
                if (bus.ack || expire) begin
                    state_d   = StIdle;
                    grant_d   = '0;
                    gnt_en_d  = 1'b0;
                    busy_d    = 1'b0;
                    ptr_d     = gidx_q + 3'd1;
                    timeout_d = expire;
                end
            end
            default: begin
                state_d  = StIdle;
                grant_d  = '0;
                gnt_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            gnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            gnt_en_q  <= gnt_en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.gnt_en  = gnt_en_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-way round-robin arbiter. It sits directly upstream of the 8-to-3 encoder.
- Converts up to eight concurrent request lines into a registered one-hot grant, plus an enable that drives the encoder's en input.
- The encoder then produces the 3-bit index of the granted requester.
- A grant is held until the consumer acknowledges it. Priority then rotates past the served requester.

Parameters:
- TIMEOUT, 16, cycles a grant may be held without ack before forced release (used only with the optional feature; legal range 2..255).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request lines; bit i = requester i
- ack  input  1  consumer has finished with the current grant (single-cycle pulse)
- grant  output  8  registered one-hot grant; bit i drives encoder input a<i>
- gnt_en  output  1  registered; high while grant is non-zero; drives encoder en
- busy  output  1  registered; high in GRANT state
- timeout  output  1  registered one-cycle pulse on forced release (tied 0 when the feature is compiled out)

Behaviour:
- Reset: all registers are updated on the rising clk edge when rst=1, regardless of other inputs.
  - grant=8'h00, gnt_en=0, busy=0, timeout=0.
  - ptr=3'd0 (the highest-priority index); state=IDLE; timeout counter=0.
  - Reset asserted during GRANT drops the grant on that same edge. No ack is required.
- State machine, two states:
  - IDLE: grant=0. If req!=0, select the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8). Next edge: grant = one-hot of that index, gnt_en=1, busy=1, state=GRANT. If req==0, stay in IDLE.
  - GRANT: grant and gnt_en are held constant.
    - ack=1 at an edge: next edge gives grant=0, gnt_en=0, busy=0, state=IDLE, ptr = granted index + 1 (mod 8; index 7 wraps to 0).
    - ack sampled in IDLE is ignored.
- Latency: request to grant is 1 cycle from IDLE.
- Re-arbitration gap: after ack there is always at least one IDLE cycle with grant=0 before the next grant. Back-to-back grants are therefore spaced at least 2 cycles apart. This gap guarantees the encoder sees en=0 between codes.
- Request drop: if the granted requester deasserts req while in GRANT, the grant is still held until ack (or timeout). Requests are sampled only in IDLE.
- Simultaneous events: in IDLE, several req bits set at once resolve by the rotating scan, so exactly one grant bit is set. In GRANT, ack and a new req in the same cycle: ack wins, and the new req is evaluated in the following IDLE cycle.
- Invariant: grant is always zero or one-hot; gnt_en == (grant != 0) == busy.
- Fairness: with all 8 requesting continuously and immediate acks, grants cycle 0,1,...,7,0. Each requester is served within 8 grants.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to GRANT and increments each GRANT cycle without ack.
  - When the counter reaches TIMEOUT-1 with no ack, the next edge applies ack-release behaviour (grant=0, state=IDLE, ptr=index+1) and pulses timeout=1 for one cycle.
  - ack in the same cycle as expiry is treated as a normal ack, so timeout stays 0.
- Undefined: no counter; the grant is held indefinitely until ack or rst; timeout output is constant 0.

Test Plan:
- Reset release, req=8'h00 for 5 cycles -> grant=8'h00, gnt_en=0, busy=0 throughout.
- From reset, req=8'h24 (bits 2,5); ack one cycle after grant; hold req -> grant sequence 8'h04, 8'h00, 8'h20, 8'h00, 8'h04, each grant 1 cycle after IDLE.
- req=8'hFF held, ack pulsed every GRANT cycle -> grant walks 8'h01, 8'h02 ... 8'h80, 8'h01 (wrap 7 to 0) with an 8'h00 cycle between each.
- Grant 3 active, req drops to 8'h00, no ack for 6 cycles -> grant stays 8'h08; ack -> grant=8'h00 next edge, ptr=4.
- rst=1 mid-GRANT (grant=8'h40) -> next edge grant=8'h00, busy=0; then req=8'h41 -> grant=8'h01 (ptr reset to 0).
- With RR_ARB_TIMEOUT_EN and TIMEOUT=4: req=8'h10, no ack -> grant=8'h10 for 4 cycles, then grant=8'h00 with timeout=1 for 1 cycle; next grant to bit 4 only after scanning 5,6,7,0..3.
